// File: rtl/step_counter.sv
// Edge-triggered up/down step counter with programmable modulus and
// selectable wrap/saturate behaviour at the range limits.
module step_counter #(
  parameter int unsigned DATA_SIZE = 5,
  parameter int unsigned WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_val,
  input  logic [DATA_SIZE-1:0] max,
  output logic [DATA_SIZE-1:0] ctr_out,
  output logic                 wrap,
  output logic                 at_max
);

  localparam int unsigned W = DATA_SIZE;

  logic         inc_q;
  logic         dec_q;
  logic         inc_evt;
  logic         dec_evt;
  logic [W-1:0] top;
  logic [W-1:0] ctr_nxt;
  logic         wrap_nxt;

  // Upper bound of the count range; max = 0 naturally yields the all-ones full range.
  assign top = max - W'(1);

  // Terminal-count flag decoded straight from the registered count.
  assign at_max = (ctr_out == top);

  // One-cycle step requests from the rising edges of the level inputs.
  assign inc_evt = inc & ~inc_q;
  assign dec_evt = dec & ~dec_q;

  // Next count and wrap pulse: load beats steps, colliding steps cancel.
  always_comb begin
    ctr_nxt  = ctr_out;
    wrap_nxt = 1'b0;
    if (load) begin
      ctr_nxt = (load_val <= top) ? load_val : top;
    end else if (inc_evt && !dec_evt) begin
      if (ctr_out < top) begin
        ctr_nxt = ctr_out + W'(1);
      end else if (WRAP != 0) begin
        ctr_nxt  = '0;
        wrap_nxt = (ctr_out == top);
      end else begin
        ctr_nxt = top;
      end
    end else if (dec_evt && !inc_evt) begin
      if (ctr_out > top) begin
        // Count left stranded above a lowered limit snaps back to the limit.
        ctr_nxt = top;
      end else if (ctr_out != '0) begin
        ctr_nxt = ctr_out - W'(1);
      end else if (WRAP != 0) begin
        ctr_nxt  = top;
        wrap_nxt = 1'b1;
      end
    end
  end

  // State register; edge history resets high so a held input needs a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_out <= '0;
      wrap    <= 1'b0;
      inc_q   <= 1'b1;
      dec_q   <= 1'b1;
    end else begin
      ctr_out <= ctr_nxt;
      wrap    <= wrap_nxt;
      inc_q   <= inc;
      dec_q   <= dec;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Directed bench: one wrapping and one saturating counter share the same stimulus.
module tb_step_counter;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         inc;
  logic         dec;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] max;
  logic [W-1:0] ctr_w;
  logic [W-1:0] ctr_s;
  logic         wrap_w;
  logic         wrap_s;
  logic         at_max_w;
  logic         at_max_s;

  int n_tests = 0;
  int n_fail  = 0;

  step_counter #(.DATA_SIZE(W), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .max(max), .ctr_out(ctr_w), .wrap(wrap_w), .at_max(at_max_w)
  );

  step_counter #(.DATA_SIZE(W), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .max(max), .ctr_out(ctr_s), .wrap(wrap_s), .at_max(at_max_s)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set the step input levels, then take one edge.
  task automatic go(input logic i, input logic d);
    inc = i;
    dec = d;
    tick();
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    load_val = W'(v);
    tick();
    load = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0; load_val = '0; max = W'(10);
    tick();
    tick();
    check_val("rst_ctr_w", int'(ctr_w), 0);
    check_val("rst_wrap_w", int'(wrap_w), 0);
    check_val("rst_ctr_s", int'(ctr_s), 0);
    check_val("rst_atmax_m10", int'(at_max_w), 0);
    max = W'(1);
    #1;
    check_val("rst_atmax_m1", int'(at_max_w), 1);
    max = W'(10);
    tick();
    rst = 1'b0;
    tick();

    // Ten separate up pulses with max = 10.
    for (int i = 1; i <= 10; i++) begin
      go(1'b1, 1'b0);
      check_val($sformatf("up_ctr_w_%0d", i), int'(ctr_w), i % 10);
      check_val($sformatf("up_wrap_w_%0d", i), int'(wrap_w), (i == 10) ? 1 : 0);
      check_val($sformatf("up_atmax_w_%0d", i), int'(at_max_w), (i == 9) ? 1 : 0);
      check_val($sformatf("up_ctr_s_%0d", i), int'(ctr_s), (i > 9) ? 9 : i);
      check_val($sformatf("up_wrap_s_%0d", i), int'(wrap_s), 0);
      go(1'b0, 1'b0);
      check_val($sformatf("up_wrapdrop_w_%0d", i), int'(wrap_w), 0);
    end

    // Held inc steps exactly once; simultaneous edges cancel.
    do_load(3);
    check_val("load3_w", int'(ctr_w), 3);
    go(1'b1, 1'b0);
    check_val("hold_first", int'(ctr_w), 4);
    for (int i = 0; i < 19; i++) tick();
    check_val("hold_after20", int'(ctr_w), 4);
    check_val("hold_after20_s", int'(ctr_s), 4);
    go(1'b0, 1'b0);
    go(1'b1, 1'b1);
    check_val("both_ctr", int'(ctr_w), 4);
    check_val("both_wrap", int'(wrap_w), 0);
    go(1'b0, 1'b0);

    // Limit behaviour at both ends, max = 10.
    do_load(9);
    go(1'b1, 1'b0);
    check_val("top_inc_ctr_s", int'(ctr_s), 9);
    check_val("top_inc_wrap_s", int'(wrap_s), 0);
    check_val("top_inc_ctr_w", int'(ctr_w), 0);
    check_val("top_inc_wrap_w", int'(wrap_w), 1);
    go(1'b0, 1'b0);
    do_load(0);
    go(1'b0, 1'b1);
    check_val("zero_dec_ctr_s", int'(ctr_s), 0);
    check_val("zero_dec_wrap_s", int'(wrap_s), 0);
    check_val("zero_dec_ctr_w", int'(ctr_w), 9);
    check_val("zero_dec_wrap_w", int'(wrap_w), 1);
    go(1'b0, 1'b0);

    // Load wins over a same-cycle edge; out-of-range loads clamp to top.
    load = 1'b1; load_val = W'(7); inc = 1'b1;
    tick();
    check_val("load7_inc_w", int'(ctr_w), 7);
    check_val("load7_inc_s", int'(ctr_s), 7);
    check_val("load7_wrap", int'(wrap_w), 0);
    load = 1'b0; inc = 1'b0;
    tick();
    do_load(12);
    check_val("load12_clamp", int'(ctr_w), 9);

    // Full range with max = 0.
    max = W'(0);
    do_load(0);
    for (int i = 0; i < 31; i++) begin
      go(1'b1, 1'b0);
      go(1'b0, 1'b0);
    end
    check_val("full_31_w", int'(ctr_w), 31);
    check_val("full_31_atmax", int'(at_max_w), 1);
    go(1'b1, 1'b0);
    check_val("full_wrap_ctr_w", int'(ctr_w), 0);
    check_val("full_wrap_w", int'(wrap_w), 1);
    check_val("full_sat_ctr_s", int'(ctr_s), 31);
    check_val("full_sat_wrap_s", int'(wrap_s), 0);
    go(1'b0, 1'b0);

    // Shrinking max leaves the count alone until the next event.
    do_load(20);
    max = W'(4);
    tick();
    check_val("shrink_hold", int'(ctr_w), 20);
    check_val("shrink_atmax", int'(at_max_w), 0);
    go(1'b1, 1'b0);
    check_val("shrink_inc_w", int'(ctr_w), 0);
    check_val("shrink_inc_wrap_w", int'(wrap_w), 0);
    check_val("shrink_inc_s", int'(ctr_s), 3);
    go(1'b0, 1'b0);
    max = W'(0);
    do_load(20);
    max = W'(4);
    go(1'b0, 1'b1);
    check_val("shrink_dec_w", int'(ctr_w), 3);
    check_val("shrink_dec_wrap", int'(wrap_w), 0);
    go(1'b0, 1'b0);

    // max = 1: single-value range.
    max = W'(1);
    do_load(0);
    check_val("m1_atmax", int'(at_max_w), 1);
    go(1'b1, 1'b0);
    check_val("m1_ctr_w", int'(ctr_w), 0);
    check_val("m1_wrap_w", int'(wrap_w), 1);
    check_val("m1_wrap_s", int'(wrap_s), 0);
    go(1'b0, 1'b0);

    // Reset overrides load; held inc across release does not count.
    max = W'(10);
    do_load(6);
    rst = 1'b1; load = 1'b1; load_val = W'(5); inc = 1'b1;
    tick();
    check_val("rst_over_load", int'(ctr_w), 0);
    load = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("rel_held_w", int'(ctr_w), 0);
    check_val("rel_held_s", int'(ctr_s), 0);
    go(1'b0, 1'b0);
    go(1'b1, 1'b0);
    check_val("rel_rise_w", int'(ctr_w), 1);
    go(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 5, meaning the counter width in bits (legal range 1..16).
REQ-002 The block SHALL have parameter WRAP, default 1, meaning the limit mode: 1 wraps at the range limits, 0 saturates at them.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port inc, input, 1, meaning a level input whose rising edge requests one up-step; it is synchronous to clk.
REQ-006 The block SHALL have port dec, input, 1, meaning a level input whose rising edge requests one down-step; it is synchronous to clk.
REQ-007 The block SHALL have port load, input, 1, meaning a level-sensitive load strobe.
REQ-008 The block SHALL have port load_val, input, DATA_SIZE, meaning the value to load.
REQ-009 The block SHALL have port max, input, DATA_SIZE, meaning the modulus; the count range is 0..top, where top = max-1 computed modulo 2^DATA_SIZE.
REQ-010 The block SHALL have port ctr_out, output, DATA_SIZE, meaning the registered count.
REQ-011 The block SHALL have port wrap, output, 1, meaning a registered one-cycle pulse that is asserted when the count wraps.
REQ-012 The block SHALL have port at_max, output, 1, meaning ctr_out == top, decoded combinationally from ctr_out and max.

Function
REQ-013 The block SHALL detect edges synchronously: inc_evt = inc & ~inc_q and dec_evt = dec & ~dec_q, where inc_q and dec_q are the values of inc and dec registered on the previous clk edge; no logic is clocked by inc or dec.
REQ-014 The block SHALL update ctr_out and wrap on the same clk edge at which the event is sampled, giving one register of latency from the input edge.
REQ-015 The block SHALL produce exactly one step per rising edge of inc or dec, regardless of how long the input is held high.
REQ-016 The block SHALL apply this priority: rst, then load, then steps; when inc_evt and dec_evt occur in the same cycle, ctr_out SHALL hold and wrap SHALL be 0.
REQ-017 On load, the block SHALL set ctr_out to load_val if load_val <= top, otherwise to top; wrap SHALL be 0, and step events in the same cycle SHALL be ignored.
REQ-018 On an up-step with ctr_out < top, the block SHALL increment ctr_out by 1.
REQ-019 On an up-step with ctr_out >= top, the block SHALL do the following:
- WRAP=1: ctr_out becomes 0; wrap is 1 only if ctr_out == top.
- WRAP=0: ctr_out becomes top; wrap is 0.
REQ-020 On a down-step with 0 < ctr_out <= top, the block SHALL decrement ctr_out by 1.
REQ-021 On a down-step with ctr_out > top (out of range after max was lowered), the block SHALL set ctr_out to top with wrap 0.
REQ-022 On a down-step with ctr_out == 0, the block SHALL do the following:
- WRAP=1: ctr_out becomes top and wrap is 1.
- WRAP=0: ctr_out holds and wrap is 0.
REQ-023 The block SHALL treat max = 0 as the full range (top = 2^DATA_SIZE - 1).
REQ-024 The block SHALL treat max = 1 as top = 0: ctr_out stays 0, and in WRAP=1 each step pulses wrap.
REQ-025 The block SHALL allow max to change at any time, with the new top taking effect on the next event; it SHALL NOT correct ctr_out without an event.
REQ-026 The block SHALL hold wrap at 0 in every cycle without a qualifying wrap.
REQ-027 The block SHALL keep ctr_out unchanged when no event is sampled.

Reset
REQ-028 While rst = 1, the block SHALL set ctr_out = 0 and wrap = 0, and SHALL set inc_q and dec_q to 1.
REQ-029 Because inc_q and dec_q reset to 1, an input held high across reset release SHALL NOT count until it falls and rises again.
REQ-030 An rst asserted mid-operation SHALL override load and any event sampled in the same cycle.
REQ-031 at_max after reset SHALL be 1 only if top = 0 (that is, max = 1).

Verification
REQ-032 Wrap count-up: DATA_SIZE=5, WRAP=1, max=10; 10 separate inc pulses from 0 -> ctr_out 1,2,...,9,0; wrap is high for one cycle, only on the 10th pulse; at_max is high while ctr_out = 9.
REQ-033 Hold and simultaneous events:
- inc held high for 20 cycles from ctr_out=3 -> ctr_out = 4 after the first edge, with no further change.
- inc and dec rising in the same cycle -> ctr_out unchanged, wrap = 0.
REQ-034 Saturate mode: WRAP=0, max=10.
- ctr_out=9, inc pulse -> ctr_out stays 9, wrap = 0.
- ctr_out=0, dec pulse -> ctr_out stays 0, wrap = 0.
REQ-035 Load:
- load=1, load_val=7, with an inc edge in the same cycle, max=10 -> ctr_out = 7.
- load_val=12 with max=10 -> ctr_out = 9.
REQ-036 Full range and shrinking max: max=0, DATA_SIZE=5.
- 31 inc pulses -> ctr_out = 31; the next pulse -> 0 with wrap = 1.
- Then ctr_out=20 with max set to 4: an inc pulse -> 0 (WRAP=1) and a dec pulse -> 3.
REQ-037 Reset release: rst held with inc=1, then released while inc stays 1 -> ctr_out stays 0; after inc drops and rises again, ctr_out = 1.
